// File: rtl/hng_pkg.sv
// Shared types and helpers for the HNG adder uncompute engine.
// hng_fwd models one forward HNG cell: (a,b,c,d) -> {p,q,r,s}.
package hng_pkg;

  localparam int HNG_WIDTH = 8;
  localparam int HNG_IDX_W = $clog2(HNG_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } hng_state_e;

  function automatic logic [3:0] hng_fwd(input logic a, input logic b,
                                         input logic c, input logic d);
    logic p, q, r, s;
    p = a;
    q = b;
    r = a ^ b ^ c;
    s = ((a ^ b) & c) ^ (a & b) ^ d;
    return {p, q, r, s};
  endfunction

endpackage

// File: rtl/hng_inv_gate.sv
// Combinational inverse HNG cell. p and q pass through unchanged,
// so only the recovered carry-in c and ancilla d are produced here.
module hng_inv_gate (
  input  logic p_i,
  input  logic q_i,
  input  logic r_i,
  input  logic s_i,
  output logic c_o,
  output logic d_o
);

  assign c_o = p_i ^ q_i ^ r_i;
  assign d_o = s_i ^ ((p_i ^ q_i) & c_o) ^ (p_i & q_i);

endmodule

// File: rtl/hng_adder_uncompute.sv
// Bit-serial MSB-to-LSB uncompute of an HNG ripple-carry chain; WIDTH cycles
// per set, holds the result in DONE until out_ready, accepts only in IDLE.
module hng_adder_uncompute
  import hng_pkg::*;
#(
  parameter int WIDTH = HNG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] d_out,
  output logic             cin_rec,
  output logic             anc_err,
  output logic             chain_err,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIDTH);

  hng_state_e       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, s_q;
  logic [WIDTH-1:0] c_q, d_q;
  logic             cin_q, anc_q, chain_q, vld_q;

  logic             bit_c, bit_d, link_bad;

  hng_inv_gate u_gate (
    .p_i (a_q[idx_q]),
    .q_i (b_q[idx_q]),
    .r_i (r_q[idx_q]),
    .s_i (s_q[idx_q]),
    .c_o (bit_c),
    .d_o (bit_d)
  );

  // Stage idx's carry-in must equal the carry-out of stage idx-1.
  assign link_bad = (idx_q != '0) && (bit_c != s_q[idx_q - IDX_W'(1)]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_W'(WIDTH - 1);
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      cin_q   <= 1'b0;
      anc_q   <= 1'b0;
      chain_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            r_q     <= r;
            s_q     <= s;
            c_q     <= '0;
            d_q     <= '0;
            cin_q   <= 1'b0;
            anc_q   <= 1'b0;
            chain_q <= 1'b0;
            idx_q   <= IDX_W'(WIDTH - 1);
            state_q <= RUN;
          end
        end
        RUN: begin
          c_q[idx_q] <= bit_c;
          d_q[idx_q] <= bit_d;
          anc_q      <= anc_q | bit_d;
          chain_q    <= chain_q | link_bad;
          if (idx_q == '0) begin
            cin_q   <= bit_c;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = vld_q;
  assign c_out     = c_q;
  assign d_out     = d_q;
  assign cin_rec   = cin_q;
  assign anc_err   = anc_q;
  assign chain_err = chain_q;

endmodule

// File: tb/tb_hng_adder_uncompute.sv
// Bench for hng_adder_uncompute: vector table plus directed backpressure,
// mid-run reset and back-to-back sequences, checked through a scoreboard.
`timescale 1ns/1ps
module tb_hng_adder_uncompute;
  import hng_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a, b, r, s, c, d;
    logic         cin, anc, chain;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0, r = '0, s = '0;
  logic         in_ready, out_valid, cin_rec, anc_err, chain_err, busy;
  logic [W-1:0] c_out, d_out;

  hng_adder_uncompute #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .r         (r),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .d_out     (d_out),
    .cin_rec   (cin_rec),
    .anc_err   (anc_err),
    .chain_err (chain_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   acc_cyc[$];
  vec_t sb[$];
  vec_t cur;
  vec_t mon_e;
  vec_t tbl[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input vec_t e, input string tag);
    chk({tag, ".c_out"}, 32'(c_out), 32'(e.c));
    chk({tag, ".d_out"}, 32'(d_out), 32'(e.d));
    chk({tag, ".cin_rec"}, 32'(cin_rec), 32'(e.cin));
    chk({tag, ".anc_err"}, 32'(anc_err), 32'(e.anc));
    chk({tag, ".chain_err"}, 32'(chain_err), 32'(e.chain));
  endtask

  // Reference built from the forward cell: pick c,d and derive r,s.
  function automatic vec_t make_vec(input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input logic [W-1:0] cv, input logic [W-1:0] dv);
    vec_t       v;
    logic [3:0] o;
    v.a = av; v.b = bv; v.c = cv; v.d = dv;
    v.r = '0; v.s = '0; v.chain = 1'b0;
    for (int i = 0; i < W; i++) begin
      o = hng_fwd(av[i], bv[i], cv[i], dv[i]);
      v.r[i] = o[1];
      v.s[i] = o[0];
    end
    for (int i = 1; i < W; i++) if (cv[i] != v.s[i-1]) v.chain = 1'b1;
    v.cin = cv[0];
    v.anc = |dv;
    return v;
  endfunction

  // Acceptances push the expected record; output handshakes pop and compare.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(cur);
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: out_valid with empty scoreboard, c_out=%0h", c_out);
        end else begin
          mon_e = sb.pop_front();
          check_out(mon_e, "sb");
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    cur = v;
    a = v.a; b = v.b; r = v.r; s = v.s;
  endtask

  task automatic wait_sb_empty(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    if (k == 40) chk({name, ".drain_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic run_txn(input vec_t v, input string name);
    int n;
    for (n = 0; n < 20 && !in_ready; n++) begin @(posedge clk); #1; end
    drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (n = 0; n < 40 && !out_valid; n++) begin @(posedge clk); #1; end
    chk({name, ".latency"}, 32'(n), 32'(W));
    out_ready = 1'b1;
    wait_sb_empty(name);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   acc0;
    vec_t v;

    tbl[0] = '{8'h5A, 8'h3C, 8'h97, 8'h78, 8'hF1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h5A, 8'h3C, 8'h97, 8'h70, 8'hF1, 8'h08, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{8'hFF, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3] = make_vec(8'hC3, 8'h96, 8'h2D, 8'h00);
    tbl[4] = make_vec(8'h0F, 8'hF0, 8'h81, 8'h01);
    tbl[5] = make_vec(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    #12;
    chk("rst.c_out", 32'(c_out), 32'd0);
    chk("rst.d_out", 32'(d_out), 32'd0);
    chk("rst.flags", 32'({cin_rec, anc_err, chain_err, out_valid, busy}), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Backpressure: result held in DONE while in_valid stays high.
    drive(tbl[1]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc0 = acc_cnt;
    drive(tbl[2]);
    for (n = 0; n < 40 && !out_valid; n++) begin @(posedge clk); #1; end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp.c_out", 32'(c_out), 32'(tbl[1].c));
      chk("bp.d_out", 32'(d_out), 32'(tbl[1].d));
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    chk("bp.no_capture", 32'(acc_cnt), 32'(acc0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.idle_in_ready", 32'(in_ready), 32'd1);
    chk("bp.out_valid_low", 32'(out_valid), 32'd0);
    chk("bp.sb_empty", 32'(sb.size()), 32'd0);

    // Reset after bits 7..5 have been written (idx now 4).
    drive(tbl[0]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid.partial_c", 32'(c_out), 32'hE0);
    rst_n = 1'b0;
    #1;
    chk("mid.c_out", 32'(c_out), 32'd0);
    chk("mid.d_out", 32'(d_out), 32'd0);
    chk("mid.flags", 32'({cin_rec, anc_err, chain_err, out_valid, busy}), 32'd0);
    chk("mid.in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid.in_ready_rel", 32'(in_ready), 32'd1);
    run_txn(tbl[2], "post_rst");

    // Back-to-back with both valids held high.
    acc_cyc.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      v = (k % 2 == 0) ? make_vec(8'($urandom), 8'($urandom), 8'($urandom), 8'h00)
                       : make_vec(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      drive(v);
      acc0 = acc_cnt;
      for (n = 0; n < 30 && acc_cnt == acc0; n++) begin @(posedge clk); #1; end
      if (n == 30) chk("b2b.accept_timeout", 32'(acc_cnt), 32'(acc0 + 1));
    end
    in_valid = 1'b0;
    wait_sb_empty("b2b");
    out_ready = 1'b0;
    chk("b2b.accepts", 32'(acc_cyc.size()), 32'd6);
    for (int k = 1; k < acc_cyc.size(); k++)
      chk($sformatf("b2b.gap%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(W + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
